// File: rtl/score_display_scheduler.sv
// score_display_scheduler
// Rotates the player and dealer hand totals on a double 7-segment display
// and breaks into that rotation to flash each newly dealt card value.
// A single 26-bit down-counter times both the dwell and the flash periods.
module score_display_scheduler #(
    parameter int DWELL     = 25_000_000,
    parameter int FLASH_LEN = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] player_score,
    input  logic [5:0] dealer_score,
    input  logic       dealer_visible,
    input  logic       card_req,
    input  logic [5:0] card_value,
    output logic       card_ack,
    output logic [5:0] disp_value,
    output logic [1:0] disp_sel,
    output logic       blank
);

    // State codes match the disp_sel source encoding, so the state register
    // itself drives disp_sel.
    localparam logic [1:0] S_PLAYER = 2'b00;
    localparam logic [1:0] S_DEALER = 2'b01;
    localparam logic [1:0] S_CARD   = 2'b10;
    localparam logic [1:0] S_IDLE   = 2'b11;

    localparam logic [25:0] DWELL_M1 = 26'(DWELL - 1);
    localparam logic [25:0] FLASH_M1 = 26'(FLASH_LEN - 1);

    localparam logic [5:0] MAX_SHOWN = 6'd39;

    // Display holds two digits; anything above 39 is clamped.
    function automatic logic [5:0] sat(input logic [5:0] x);
        return (x > MAX_SHOWN) ? MAX_SHOWN : x;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  ret_q,   ret_d;
    logic [25:0] cnt_q,   cnt_d;
    logic        ack_q,   ack_d;
    logic [5:0]  value_q, value_d;
    logic        blank_q, blank_d;

    logic        cnt_zero;
    assign cnt_zero = (cnt_q == 26'd0);

    // Next-state, counter and return-state selection in priority order:
    // enable low, accepted card request, dealer hidden, counter expiry.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        if (!enable) begin
            // Abandon everything, including a flash in progress; no ack.
            state_d = S_IDLE;
            cnt_d   = 26'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PLAYER;
                    cnt_d   = DWELL_M1;
                end
                S_PLAYER, S_DEALER: begin
                    if (card_req) begin
                        state_d = S_CARD;
                        ret_d   = state_q;
                        cnt_d   = FLASH_M1;
                        ack_d   = 1'b1;
                    end else if (state_q == S_DEALER && !dealer_visible) begin
                        state_d = S_PLAYER;
                        cnt_d   = DWELL_M1;
                    end else if (cnt_zero) begin
                        cnt_d = DWELL_M1;
                        if (state_q == S_PLAYER)
                            state_d = dealer_visible ? S_DEALER : S_PLAYER;
                        else
                            state_d = S_PLAYER;
                    end else begin
                        cnt_d = cnt_q - 26'd1;
                    end
                end
                S_CARD: begin
                    // Requests are never taken here, so a request still held
                    // on the return edge is taken one cycle later.
                    if (cnt_zero) begin
                        state_d = ret_q;
                        cnt_d   = DWELL_M1;
                    end else begin
                        cnt_d = cnt_q - 26'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 26'd0;
                end
            endcase
        end
    end

    // Output values are derived from the state being entered so the
    // registered outputs describe the state held after the edge.
    always_comb begin
        value_d = value_q;
        blank_d = 1'b0;
        case (state_d)
            S_PLAYER: value_d = sat(player_score);
            S_DEALER: value_d = sat(dealer_score);
            S_CARD:   value_d = ack_d ? sat(card_value) : value_q;
            default: begin
                value_d = 6'd0;
                blank_d = 1'b1;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ret_q   <= S_PLAYER;
            cnt_q   <= 26'd0;
            ack_q   <= 1'b0;
            value_q <= 6'd0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            value_q <= value_d;
            blank_q <= blank_d;
        end
    end

    assign card_ack   = ack_q;
    assign disp_value = value_q;
    assign disp_sel   = state_q;
    assign blank      = blank_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Self-checking bench for score_display_scheduler (DWELL=4, FLASH_LEN=3).
// A cycle-level model that counts elapsed display cycles upward predicts
// every output each cycle; directed scenarios are followed by random traffic.
module tb_score_display_scheduler;

    localparam int DWELL = 4;
    localparam int FLASH = 3;

    logic       clk = 1'b0;
    logic       reset, enable, dealer_visible, card_req;
    logic [5:0] player_score, dealer_score, card_value;
    logic       card_ack, blank;
    logic [5:0] disp_value;
    logic [1:0] disp_sel;

    score_display_scheduler #(.DWELL(DWELL), .FLASH_LEN(FLASH)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .player_score(player_score), .dealer_score(dealer_score),
        .dealer_visible(dealer_visible), .card_req(card_req),
        .card_value(card_value), .card_ack(card_ack),
        .disp_value(disp_value), .disp_sel(disp_sel), .blank(blank)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int acks   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: mode 0=player 1=dealer 2=card 3=idle (display source),
    // age = number of cycles the current item has been on display.
    int m_mode = 3, m_ret = 0, m_age = 0, m_val = 0, m_ack = 0;

    function automatic int clamp(input int x);
        return (x > 39) ? 39 : x;
    endfunction

    function automatic int score_of(input int mode);
        return (mode == 0) ? clamp(int'(player_score)) : clamp(int'(dealer_score));
    endfunction

    task automatic model_step();
        m_ack = 0;
        if (reset) begin
            m_mode = 3; m_ret = 0; m_age = 0; m_val = 0;
        end else if (!enable) begin
            m_mode = 3; m_age = 0; m_val = 0;
        end else if (m_mode == 3) begin
            m_mode = 0; m_age = 1; m_val = score_of(0);
        end else if (m_mode == 2) begin
            if (m_age == FLASH) begin
                m_mode = m_ret; m_age = 1; m_val = score_of(m_mode);
            end else m_age++;
        end else if (card_req) begin
            m_ret = m_mode; m_mode = 2; m_age = 1; m_ack = 1;
            m_val = clamp(int'(card_value));
        end else begin
            if (m_mode == 1 && !dealer_visible) begin
                m_mode = 0; m_age = 1;
            end else if (m_age == DWELL) begin
                m_mode = (m_mode == 0 && dealer_visible) ? 1 : 0; m_age = 1;
            end else m_age++;
            m_val = score_of(m_mode);
        end
    endtask

    // One clock: predict from the inputs present at the edge, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("disp_sel",   int'(disp_sel),   m_mode);
        chk("disp_value", int'(disp_value), m_val);
        chk("blank",      int'(blank),      (m_mode == 3) ? 1 : 0);
        chk("card_ack",   int'(card_ack),   m_ack);
        if (card_ack) acks++;
    endtask

    task automatic wait_sel(input int want);
        for (int i = 0; i < 40 && int'(disp_sel) != want; i++) tick();
        chk("wait_sel", int'(disp_sel), want);
    endtask

    initial begin
        int n;
        reset = 1; enable = 0; dealer_visible = 0; card_req = 0;
        player_score = 0; dealer_score = 0; card_value = 0;
        @(negedge clk);
        tick(); tick();
        chk("rst_sel", int'(disp_sel), 3);
        chk("rst_blank", int'(blank), 1);
        chk("rst_val", int'(disp_value), 0);

        // Player only: stays on player forever.
        reset = 0; enable = 1; player_score = 17;
        tick();
        chk("first_sel", int'(disp_sel), 0);
        chk("first_val", int'(disp_value), 17);
        n = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (disp_sel != 2'b00) n++; end
        chk("player_only", n, 0);

        // Alternation with saturated dealer total: 8 of 16 cycles on dealer.
        dealer_visible = 1; dealer_score = 45;
        wait_sel(1);
        n = 0;
        for (int i = 0; i < 16; i++) begin tick(); if (disp_sel == 2'b01) n++; end
        chk("alt_count", n, 8);

        // Card flash during dealer display.
        wait_sel(1);
        card_req = 1; card_value = 10;
        tick();
        chk("flash_ack", int'(card_ack), 1);
        chk("flash_val", int'(disp_value), 10);
        card_req = 0;
        tick(); tick();
        chk("flash_hold", int'(disp_sel), 2);
        tick();
        chk("flash_ret", int'(disp_sel), 1);

        // Request held through a whole flash: second value taken after return.
        acks = 0;
        wait_sel(1);
        card_req = 1; card_value = 10;
        tick();
        card_value = 7;
        tick(); tick(); tick();
        chk("ret_edge_sel", int'(disp_sel), 1);
        chk("ret_edge_ack", int'(card_ack), 0);
        tick();
        chk("second_ack", int'(card_ack), 1);
        chk("second_val", int'(disp_value), 7);
        card_req = 0;
        chk("ack_pulses", acks, 2);

        // Enable dropped during the 2nd flash cycle.
        tick();
        enable = 0;
        tick();
        chk("dis_sel", int'(disp_sel), 3);
        chk("dis_val", int'(disp_value), 0);
        enable = 1;
        tick();
        chk("resume_sel", int'(disp_sel), 0);

        // Reset during a flash, then dealer hidden mid-dealer.
        wait_sel(1);
        card_req = 1; card_value = 33;
        tick();
        card_req = 0;
        reset = 1;
        tick();
        chk("rst_flash_sel", int'(disp_sel), 3);
        chk("rst_flash_blank", int'(blank), 1);
        reset = 0;
        wait_sel(1);
        dealer_visible = 0;
        tick();
        chk("hide_sel", int'(disp_sel), 0);

        // Random traffic; the requester holds card_req until it sees an ack.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            enable         = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) dealer_visible = ~dealer_visible;
            player_score   = 6'($urandom);
            dealer_score   = 6'($urandom);
            if (!card_req && $urandom_range(0, 5) == 0) begin
                card_req   = 1;
                card_value = 6'($urandom);
            end
            tick();
            if (card_ack) card_req = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/score_display_scheduler.md
SCORE_DISPLAY_SCHEDULER -- requirements
Module: score_display_scheduler

Interface
REQ-001 Parameter DWELL, default 25_000_000, SHALL set the cycles each score is shown before rotating (legal range 2..2^26-1).
REQ-002 Parameter FLASH_LEN, default 12_500_000, SHALL set the cycles a newly dealt card value is shown (legal range 2..2^26-1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 enable  input  1  SHALL allow the display to run; low forces IDLE.
REQ-006 player_score  input  6  SHALL carry the player hand total (unsigned).
REQ-007 dealer_score  input  6  SHALL carry the dealer hand total (unsigned).
REQ-008 dealer_visible  input  1  SHALL allow the dealer total into the rotation when high.
REQ-009 card_req  input  1  SHALL be a level request to flash card_value; held high until card_ack is seen.
REQ-010 card_value  input  6  SHALL carry the dealt card value, valid while card_req is high.
REQ-011 card_ack  output  1  SHALL be a one-cycle pulse accepting a card request.
REQ-012 disp_value  output  6  SHALL drive the double 7-segment display value input; always 0..39.
REQ-013 disp_sel  output  2  SHALL report the source: 00 player, 01 dealer, 10 card, 11 idle.
REQ-014 blank  output  1  SHALL be high when the display content is meaningless (IDLE).

Function
REQ-015 The block SHALL implement the states IDLE, SHOW_PLAYER, SHOW_DEALER and SHOW_CARD, plus a 26-bit down-counter cnt.
REQ-016 All outputs SHALL be registers, loaded at each edge from the next state, so outputs reflect the state held after that edge.
REQ-017 Saturation: sat(x) = x if x <= 39, else 39; disp_value SHALL always be sat() of its source.
REQ-018 Edge priority SHALL be: reset, then enable low, then an accepted card_req, then dealer_visible loss, then cnt expiry.
REQ-019 In IDLE, enable=1 SHALL move to SHOW_PLAYER with cnt=DWELL-1.
REQ-020 Any state with enable=0 SHALL move to IDLE at the next edge; an in-progress flash is abandoned and no ack is issued.
REQ-021 In SHOW_PLAYER/SHOW_DEALER, cnt SHALL decrement each cycle; at cnt==0 the block SHALL reload cnt=DWELL-1 and select the next source.
REQ-022 On expiry, SHOW_PLAYER SHALL go to SHOW_DEALER if dealer_visible=1, else remain in SHOW_PLAYER; SHOW_DEALER SHALL go to SHOW_PLAYER.
REQ-023 In SHOW_DEALER, dealer_visible=0 SHALL force SHOW_PLAYER with cnt=DWELL-1 at the next edge.
REQ-024 While in SHOW_PLAYER/SHOW_DEALER, disp_value SHALL track the live score each cycle (one-cycle latency).
REQ-025 card_req=1 in SHOW_PLAYER/SHOW_DEALER with enable=1 SHALL, at the same edge, do all of the following: enter SHOW_CARD, pulse card_ack=1 for exactly one cycle, latch sat(card_value) into disp_value, load cnt=FLASH_LEN-1, and record the interrupted state.
REQ-026 card_req SHALL NOT be acknowledged in IDLE or SHOW_CARD; it stays pending and is accepted on the first eligible edge.
REQ-027 In SHOW_CARD, disp_value SHALL hold the latched card value; at cnt==0 the block SHALL return to the recorded state with cnt=DWELL-1.
REQ-028 If card_req is still high on the return edge from SHOW_CARD, it SHALL be accepted one cycle later, never on the return edge itself.
REQ-029 In every state other than IDLE, blank SHALL be 0.

Reset
REQ-030 reset=1 at an edge SHALL set state=IDLE, cnt=0, card_ack=0, disp_value=0, disp_sel=11, blank=1, and the recorded state=SHOW_PLAYER, regardless of the other inputs.
REQ-031 Reset asserted mid-flash or mid-dwell SHALL discard all progress; the first state after release SHALL be IDLE.

Verification (DWELL=4, FLASH_LEN=3)
REQ-032 Reset, then enable=1, player_score=17, dealer_visible=0 -> one cycle later disp_sel=00, disp_value=17, blank=0; the block stays on 00 indefinitely.
REQ-033 The REQ-032 setup with dealer_visible=1 and dealer_score=45 -> alternating 4 cycles at 00 with value 17 and 4 cycles at 01 with value 39 (saturated).
REQ-034 card_req=1 with card_value=10 during SHOW_DEALER -> card_ack high for one cycle, disp_sel=10, disp_value=10 for 3 cycles, then disp_sel=01 for 4 cycles.
REQ-035 card_req held through an entire flash with a second value of 7 -> the return edge shows 01/00, the next edge shows a second ack and value 7; exactly two ack pulses are seen.
REQ-036 enable dropped during the 2nd flash cycle -> next cycle disp_sel=11, blank=1, disp_value=0, no ack; enable=1 again -> resumes at SHOW_PLAYER.
REQ-037 reset pulsed during SHOW_CARD -> outputs match REQ-030 on the next cycle; dealer_visible dropped during SHOW_DEALER -> disp_sel=00 at the next edge.
